// File: rtl/window_ctrl_if.sv
// window_ctrl_if: handshake bundle between a pixel source / window sink and
// the window controller. The master side is the surrounding pipeline, the
// slave side is window_ctrl itself.
interface window_ctrl_if #(
   parameter int IMG_W = 10,
   parameter int IMG_H = 10
);
   logic                     start;
   logic                     in_valid;
   logic                     in_ready;
   logic                     shift_en;
   logic                     win_valid;
   logic                     win_ready;
   logic [$clog2(IMG_H)-1:0] win_row;
   logic [$clog2(IMG_W)-1:0] win_col;
   logic                     busy;
   logic                     frame_done;

   modport master (
      output start, in_valid, win_ready,
      input  in_ready, shift_en, win_valid, win_row, win_col, busy, frame_done
   );

   modport slave (
      input  start, in_valid, win_ready,
      output in_ready, shift_en, win_valid, win_row, win_col, busy, frame_done
   );
endinterface

// File: rtl/window_ctrl.sv
// window_ctrl: sliding KxK window controller for a raster pixel stream.
// Tracks the row/column of each accepted pixel, advances the window datapath
// via shift_en and flags a complete window one cycle after the pixel that
// completes it. Window handshake is valid/ready with back-pressure onto the
// pixel input.
// Optional build macro: WINDOW_CTRL_STRIDE2_EN presents only windows whose
// top-left row and column are both even (pixels are still all consumed).
module window_ctrl #(
   parameter int IMG_W = 10,
   parameter int IMG_H = 10,
   parameter int K     = 3
) (
   input  logic          clk,
   input  logic          rst,
   window_ctrl_if.slave  bus
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;
   logic          win_valid_q;
   logic [RW-1:0] win_row_q;
   logic [CW-1:0] win_col_q;

   logic          in_ready;
   logic          accept;
   logic          consume;
   logic          at_last;
   logic          at_first_win;
   logic          stride_ok;
   logic          win_gen;
   logic          done_cond;
   logic [RW-1:0] cand_row;
   logic [CW-1:0] cand_col;

   // The input stalls whenever a presented window is not being taken, so a
   // window is never overwritten before the sink sees it. Reset forces the
   // handshake closed even if the state register still holds a busy state.
   assign in_ready     = !rst && (state_q == FILL || state_q == RUN) &&
                         (!win_valid_q || bus.win_ready);
   assign accept       = in_ready && bus.in_valid;
   assign consume      = win_valid_q && bus.win_ready;
   assign at_last      = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign at_first_win = (row_q == ROW_WIN0) && (col_q == COL_WIN0);
   assign cand_row     = row_q - ROW_WIN0;
   assign cand_col     = col_q - COL_WIN0;

`ifdef WINDOW_CTRL_STRIDE2_EN
   assign stride_ok = !cand_row[0] && !cand_col[0];
`else
   assign stride_ok = 1'b1;
`endif

   assign win_gen = accept && (row_q >= ROW_WIN0) && (col_q >= COL_WIN0) && stride_ok;

   // Next-state logic; frame end is the cycle FLUSH sees no pending window left.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      done_cond = 1'b0;
      unique case (state_q)
         IDLE:  if (bus.start) state_d = FILL;
         FILL: begin
            if (accept && at_last)           state_d = FLUSH;
            else if (accept && at_first_win) state_d = RUN;
         end
         RUN:   if (accept && at_last) state_d = FLUSH;
         FLUSH: begin
            if (!win_valid_q || bus.win_ready) begin
               state_d   = IDLE;
               done_cond = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge like any other input; it
      // needs no sensitivity-list entry and must be held across an edge.
      if (rst) state_q <= IDLE;
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      else     state_q <= state_d;
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else if (state_q == IDLE && bus.start) begin
         row_q <= '0;
         col_q <= '0;
      end else if (accept) begin
         if (at_last) begin
            row_q <= '0;
            col_q <= '0;
         end else if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   // Presented window: a new window replaces a consumed one with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
      end else if (win_gen) begin
         win_valid_q <= 1'b1;
         win_row_q   <= cand_row;
         win_col_q   <= cand_col;
      end else if (consume) begin
         win_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.shift_en   = accept;
   assign bus.win_valid  = win_valid_q;
   assign bus.win_row    = win_row_q;
   assign bus.win_col    = win_col_q;
   assign bus.busy       = !rst && (state_q != IDLE);
   assign bus.frame_done = !rst && done_cond;
endmodule

// File: tb/tb_window_ctrl.sv
// tb_window_ctrl: directed bench for window_ctrl at default geometry.
// Stimulus: back-to-back frame, sink stall, toggling source with a stray
// start, mid-frame reset and restart. A negedge monitor logs consumed windows
// and handshake counts; expected values are hand-computed constants.
module tb_window_ctrl;
   localparam int IMG_W = 10;
   localparam int IMG_H = 10;
   localparam int K     = 3;
`ifdef WINDOW_CTRL_STRIDE2_EN
   localparam int STEP    = 2;
   localparam int NWC     = 4;   // columns 0,2,4,6
   localparam int EXP_WIN = 16;
`else
   localparam int STEP    = 1;
   localparam int NWC     = 8;   // columns 0..7
   localparam int EXP_WIN = 64;
`endif
   localparam int FIRST_ACC = 23;  // pixel (2,2) is the 23rd in raster order
   localparam int NPIX      = 100;
   localparam int BUDGET    = 2000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   window_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

   window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int row;
      int col;
      int acc;
   } win_t;

   win_t win_q[$];
   int   acc_cnt = 0;
   int   sh_cnt  = 0;
   int   fd_cnt  = 0;
   logic prev_hold = 1'b0;
   logic prev_rst  = 1'b1;
   logic [31:0] prev_row = '0;
   logic [31:0] prev_col = '0;

   // Monitor: handshake invariants every cycle plus a log of consumed windows.
   always @(negedge clk) begin
      if (!rst) begin
         check("shift_en_eq_accept", bus.shift_en, bus.in_valid & bus.in_ready);
         if (bus.win_valid && !bus.win_ready)
            check("stall_in_ready", bus.in_ready, 0);
         if (prev_hold && !prev_rst) begin
            check("hold_valid", bus.win_valid, 1);
            check("hold_row", bus.win_row, prev_row);
            check("hold_col", bus.win_col, prev_col);
         end
         if (bus.win_valid && bus.win_ready)
            win_q.push_back('{row: int'(bus.win_row), col: int'(bus.win_col), acc: acc_cnt});
         acc_cnt += int'(bus.in_valid & bus.in_ready);
         sh_cnt  += int'(bus.shift_en);
         fd_cnt  += int'(bus.frame_done);
         prev_hold = bus.win_valid & !bus.win_ready;
         prev_row  = 32'(bus.win_row);
         prev_col  = 32'(bus.win_col);
      end else begin
         prev_hold = 1'b0;
      end
      prev_rst = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: back-to-back, 1: in_valid toggling + stray start, 2: 5-cycle sink stall
   task automatic run_frame(input int mode, input string name);
      int w0 = win_q.size();
      int s0 = sh_cnt;
      int f0 = fd_cnt;
      int a0 = acc_cnt;
      int cyc = 0;
      int stall = 0;
      bit stalled = 1'b0;
      int nw;
      bus.start     = 1'b1;
      bus.in_valid  = 1'b0;
      bus.win_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      #3 check({name, "_busy"}, bus.busy, 1);
      while (fd_cnt == f0 && cyc < BUDGET) begin
         bus.in_valid  = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
         bus.win_ready = 1'b1;
         bus.start     = (mode == 1 && cyc == 15);
         if (mode == 2) begin
            if (stall > 0) begin
               bus.win_ready = 1'b0;
               stall--;
            end else if (!stalled && bus.win_valid && (win_q.size() - w0) >= 5) begin
               stalled       = 1'b1;
               stall         = 4;
               bus.win_ready = 1'b0;
            end
         end
         #3;
         if (!bus.win_ready) begin
            check({name, "_stall_in_ready"}, bus.in_ready, 0);
            check({name, "_stall_shift"}, bus.shift_en, 0);
         end
         tick();
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.start     = 1'b0;
      bus.win_ready = 1'b1;
      check({name, "_done_in_time"}, cyc < BUDGET, 1);
      repeat (3) tick();
      #3;
      check({name, "_busy_after"}, bus.busy, 0);
      check({name, "_frame_done_once"}, fd_cnt - f0, 1);
      check({name, "_shift_count"}, sh_cnt - s0, NPIX);
      if (mode == 2) check({name, "_stall_seen"}, stalled, 1);
      nw = win_q.size() - w0;
      check({name, "_win_count"}, nw, EXP_WIN);
      if (nw > 0) check({name, "_first_latency"}, win_q[w0].acc - a0, FIRST_ACC);
      for (int i = 0; i < nw && i < EXP_WIN; i++) begin
         check({name, "_win_row"}, win_q[w0 + i].row, (i / NWC) * STEP);
         check({name, "_win_col"}, win_q[w0 + i].col, (i % NWC) * STEP);
      end
   endtask

   initial begin
      int a0;
      int f0;
      int cyc;
      rst           = 1'b1;
      bus.start     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.win_ready = 1'b1;
      repeat (2) tick();
      #3;
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_shift_en", bus.shift_en, 0);
      check("rst_win_valid", bus.win_valid, 0);
      check("rst_win_row", bus.win_row, 0);
      check("rst_win_col", bus.win_col, 0);
      check("rst_frame_done", bus.frame_done, 0);
      tick();
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      #3 check("idle_in_ready", bus.in_ready, 0);

      run_frame(0, "b2b");
      run_frame(2, "stall");
      run_frame(1, "toggle");

      // Mid-frame reset after 40 accepted pixels with a window pending.
      a0 = acc_cnt;
      f0 = fd_cnt;
      cyc = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      while ((acc_cnt - a0) < 40 && cyc < BUDGET) begin
         bus.in_valid  = 1'b1;
         bus.win_ready = 1'b1;
         tick();
         cyc++;
      end
      check("mid_pixels", acc_cnt - a0, 40);
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.win_ready = 1'b0;
      #3;
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_shift_en", bus.shift_en, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_frame_done", bus.frame_done, 0);
      tick();
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.win_ready = 1'b1;
      #3;
      check("post_rst_win_valid", bus.win_valid, 0);
      check("post_rst_win_row", bus.win_row, 0);
      check("post_rst_win_col", bus.win_col, 0);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_in_ready", bus.in_ready, 0);
      check("post_rst_no_done", fd_cnt - f0, 0);
      run_frame(0, "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/window_ctrl.md
WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 10, pixels per image row (K <= IMG_W).
REQ-002 SHALL have parameter IMG_H, default 10, rows per frame (K <= IMG_H).
REQ-003 SHALL have parameter K, default 3, square window edge (K >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  begin a frame; sampled in IDLE only.
REQ-007 SHALL have port in_valid  input  1  upstream pixel available.
REQ-008 SHALL have port in_ready  output  1  controller accepts a pixel this cycle.
REQ-009 SHALL have port shift_en  output  1  advance the window datapath by one pixel.
REQ-010 SHALL have port win_valid  output  1  a complete window is presented.
REQ-011 SHALL have port win_ready  input  1  downstream consumes the window.
REQ-012 SHALL have port win_row  output  $clog2(IMG_H)  top-left row of the presented window.
REQ-013 SHALL have port win_col  output  $clog2(IMG_W)  top-left column of the presented window.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, RUN, FLUSH.
REQ-017 IDLE->FILL when start=1; row/col counters cleared to 0 on that edge; start ignored in all other states.
REQ-018 Accept = in_valid & in_ready; in_ready = (state FILL or RUN) & (!win_valid | win_ready), combinational.
REQ-019 shift_en SHALL equal accept in the same cycle; shift_en=0 whenever in_ready=0.
REQ-020 On accept, col increments; at col=IMG_W-1 col wraps to 0 and row increments.
REQ-021 Accepted pixel at (r,c) with r>=K-1 and c>=K-1 SHALL set win_valid=1 next cycle, win_row=r-(K-1), win_col=c-(K-1).
REQ-022 win_valid SHALL hold, with win_row/win_col stable, until win_valid & win_ready.
REQ-023 Consume and new window in the same cycle: win_valid stays 1, coordinates update, no bubble.
REQ-024 Consume with no new window: win_valid=0 next cycle.
REQ-025 FILL->RUN on the accept that first produces a window (r=K-1, c=K-1).
REQ-026 RUN->FLUSH on accept of pixel (IMG_H-1, IMG_W-1); no further pixels accepted.
REQ-027 FLUSH->IDLE when win_valid=0 or the pending window is consumed; frame_done=1 for exactly that cycle.
REQ-028 Throughput SHALL be one pixel per cycle with win_ready held high; window latency one cycle after accept.
REQ-029 Frame SHALL produce exactly (IMG_H-K+1)*(IMG_W-K+1) windows in raster order.

Reset
REQ-030 rst SHALL override all inputs: state=IDLE, row=col=0, win_valid=0, win_row=win_col=0, frame_done=0, busy=0.
REQ-031 rst mid-frame SHALL discard any pending window with no frame_done pulse; in_ready=shift_en=0 during rst.
REQ-032 First start after rst deassertion SHALL be honoured on the next cycle.

Configuration
REQ-033 Macro WINDOW_CTRL_STRIDE2_EN defined: only windows with even win_row and even win_col are presented; others are not flagged, but their pixels are still accepted and shifted.
REQ-034 Macro undefined: stride 1, every position per REQ-029; no stride logic compiled in.

Verification
REQ-035 Defaults, start, 100 pixels back-to-back, win_ready=1 -> 64 windows, first (0,0) one cycle after the 23rd accept, last (7,7), one frame_done pulse.
REQ-036 win_ready low 5 cycles while win_valid=1 -> in_ready=0, shift_en=0, win_row/col stable, no window lost or duplicated.
REQ-037 in_valid toggling each cycle -> 64 windows, raster order, shift_en count = 100.
REQ-038 rst asserted after 40 pixels -> all outputs 0 next cycle, no frame_done; restart yields full 64-window frame.
REQ-039 start pulsed while busy -> ignored, counters unchanged.
REQ-040 WINDOW_CTRL_STRIDE2_EN defined, defaults -> 16 windows at rows/cols {0,2,4,6}, frame_done once.
